// File: rtl/matrix_pkg.sv
// -----------------------------------------------------------------------------
// matrix_pkg
// Shared definitions for the byte-serial matrix ALU front end:
//   - geometry of the flattened operand/result buses (MAX_DIM, ELEM_W, FLAT_W)
//   - ALU opcode encodings OP_NOP .. OP_DET
//   - controller state enumeration
//   - idx(r,c): bit offset of element (r,c) inside a flattened bus
// -----------------------------------------------------------------------------
package matrix_pkg;

    localparam int MAX_DIM = 5;
    localparam int ELEM_W  = 8;
    localparam int FLAT_W  = MAX_DIM * MAX_DIM * ELEM_W;   // 200

    localparam logic [2:0] OP_NOP = 3'b000;
    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_SUB = 3'b010;
    localparam logic [2:0] OP_MUL = 3'b011;
    localparam logic [2:0] OP_OPP = 3'b100;
    localparam logic [2:0] OP_TRN = 3'b101;
    localparam logic [2:0] OP_SCL = 3'b110;
    localparam logic [2:0] OP_DET = 3'b111;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD_A  = 3'd1,
        ST_LOAD_B  = 3'd2,
        ST_EXEC    = 3'd3,
        ST_CAPTURE = 3'd4,
        ST_UNLOAD  = 3'd5
    } state_t;

    // Row stride is always MAX_DIM, independent of the active matrix size.
    function automatic int idx(input logic [2:0] r, input logic [2:0] c);
        return (int'(r) * MAX_DIM + int'(c)) * ELEM_W;
    endfunction

endpackage

// File: rtl/matrix_index_counter.sv
// -----------------------------------------------------------------------------
// matrix_index_counter
// Row/column walker over an n x n matrix in row-major order. Shared by the
// load path (writing operand slots) and the unload path (reading result slots).
//
// Ports:
//   clock, reset      rising-edge clock, synchronous active-high reset
//   size              active dimension n (2..5)
//   clear             return to (0,0); has priority over step
//   step              advance one element; column wraps at n-1 and bumps row
//   row, col          current element position
//   last              high while the position is (n-1, n-1)
// -----------------------------------------------------------------------------
module matrix_index_counter
    import matrix_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic [2:0] size,
    input  logic       clear,
    input  logic       step,
    output logic [2:0] row,
    output logic [2:0] col,
    output logic       last
);

    logic [2:0] row_reg;
    logic [2:0] col_reg;
    logic [2:0] size_m1;

    assign size_m1 = size - 3'd1;
    assign last    = (row_reg == size_m1) && (col_reg == size_m1);
    assign row     = row_reg;
    assign col     = col_reg;

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            row_reg <= 3'd0;
            col_reg <= 3'd0;
        end else if (step) begin
            if (col_reg == size_m1) begin
                col_reg <= 3'd0;
                // Wrapping the row as well keeps the walker in range if it is
                // stepped past the final element before being cleared.
                row_reg <= last ? 3'd0 : row_reg + 3'd1;
            end else begin
                col_reg <= col_reg + 3'd1;
            end
        end
    end

endmodule

// File: rtl/matrix_link_ctrl.sv
// -----------------------------------------------------------------------------
// matrix_link_ctrl
// Byte-serial front end for the matrix ALU. Takes a command, streams operand A
// (and B for add/sub/mul) into the 200-bit flattened buses, holds the opcode on
// the ALU until done, captures the result and streams it back byte by byte.
//
// Build option: define MATRIX_LINK_TIMEOUT_EN to abort EXEC after
// TIMEOUT_CYCLES without done, answering with the error response.
//
// Ports:
//   clock, reset                 clock / synchronous active-high reset
//   cmd_valid/ready, cmd_opcode, cmd_size, cmd_scalar   command channel
//   in_valid/ready, in_data      operand element stream (row-major)
//   out_valid/ready, out_data, out_last, out_ovf, out_err  result stream
//   A_flat, B_flat, opcode, scalar, matrix_size          operands to ALU
//   C_flat, number, overflow_flag, done                  results from ALU
//   busy                         high whenever not IDLE
// -----------------------------------------------------------------------------
module matrix_link_ctrl
    import matrix_pkg::*;
#(
    parameter int SETTLE_CYCLES  = 1,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_opcode,
    input  logic [2:0]        cmd_size,
    input  logic [ELEM_W-1:0] cmd_scalar,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ELEM_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ELEM_W-1:0] out_data,
    output logic              out_last,
    output logic              out_ovf,
    output logic              out_err,
    output logic [FLAT_W-1:0] A_flat,
    output logic [FLAT_W-1:0] B_flat,
    output logic [2:0]        opcode,
    output logic [ELEM_W-1:0] scalar,
    output logic [2:0]        matrix_size,
    input  logic [FLAT_W-1:0] C_flat,
    input  logic [ELEM_W-1:0] number,
    input  logic              overflow_flag,
    input  logic              done,
    output logic              busy
);

    localparam int NUM_SLOTS = MAX_DIM * MAX_DIM;
    localparam int CNT_MAX   = (SETTLE_CYCLES > TIMEOUT_CYCLES) ? SETTLE_CYCLES : TIMEOUT_CYCLES;
    localparam int CNT_W     = $clog2(CNT_MAX + 2);

    state_t state_reg;
    state_t state_next;

    // Latched command and captured result
    logic [2:0]        op_reg;
    logic [2:0]        size_reg;
    logic [ELEM_W-1:0] scalar_reg;
    logic              err_reg;
    logic              ovf_reg;
    logic [ELEM_W-1:0] number_reg;
    logic [FLAT_W-1:0] c_reg;
    logic [CNT_W-1:0]  exec_cnt_reg;

    // Control strobes from the next-state logic
    logic accept_cmd;
    logic cmd_bad;
    logic load_beat;
    logic capture;
    logic exec_timeout;
    logic cnt_clear;
    logic cnt_step;

    logic [2:0] cnt_row;
    logic [2:0] cnt_col;
    logic       cnt_last;
    logic [4:0] slot_idx;
    logic       two_op;
    logic       settle_ok;
    logic       resp_last;
    logic [ELEM_W-1:0] c_slot [NUM_SLOTS];
    logic [ELEM_W-1:0] resp_byte;

    matrix_index_counter u_index (
        .clock (clock),
        .reset (reset),
        .size  (size_reg),
        .clear (cnt_clear),
        .step  (cnt_step),
        .row   (cnt_row),
        .col   (cnt_col),
        .last  (cnt_last)
    );

    assign slot_idx  = 5'(cnt_row) * 5'(MAX_DIM) + 5'(cnt_col);
    assign two_op    = (op_reg == OP_ADD) || (op_reg == OP_SUB) || (op_reg == OP_MUL);
    assign cmd_bad   = (cmd_opcode == OP_NOP) || (cmd_size < 3'd2) || (cmd_size > 3'(MAX_DIM));
    // exec_cnt_reg counts completed EXEC cycles; +1 includes the current one.
    assign settle_ok = (int'(exec_cnt_reg) + 1) >= SETTLE_CYCLES;

`ifdef MATRIX_LINK_TIMEOUT_EN
    logic timeout_hit;
    assign timeout_hit = (int'(exec_cnt_reg) + 1) >= TIMEOUT_CYCLES;
`endif

    // Error and determinant responses are a single byte.
    assign resp_last = err_reg || (op_reg == OP_DET) || cnt_last;

    // ------------------------------------------------------------------
    // Next-state and strobes
    // ------------------------------------------------------------------
    always_comb begin
        state_next   = state_reg;
        accept_cmd   = 1'b0;
        load_beat    = 1'b0;
        capture      = 1'b0;
        exec_timeout = 1'b0;
        cnt_clear    = 1'b0;
        cnt_step     = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                cnt_clear = 1'b1;
                if (cmd_valid) begin
                    accept_cmd = 1'b1;
                    state_next = cmd_bad ? ST_UNLOAD : ST_LOAD_A;
                end
            end
            ST_LOAD_A: begin
                if (in_valid) begin
                    load_beat = 1'b1;
                    cnt_step  = 1'b1;
                    if (cnt_last) begin
                        cnt_clear  = 1'b1;
                        state_next = two_op ? ST_LOAD_B : ST_EXEC;
                    end
                end
            end
            ST_LOAD_B: begin
                if (in_valid) begin
                    load_beat = 1'b1;
                    cnt_step  = 1'b1;
                    if (cnt_last) begin
                        cnt_clear  = 1'b1;
                        state_next = ST_EXEC;
                    end
                end
            end
            ST_EXEC: begin
                if (done && settle_ok) begin
                    state_next = ST_CAPTURE;
                end
`ifdef MATRIX_LINK_TIMEOUT_EN
                else if (timeout_hit) begin
                    exec_timeout = 1'b1;
                    state_next   = ST_UNLOAD;
                end
`endif
            end
            ST_CAPTURE: begin
                capture    = 1'b1;
                cnt_clear  = 1'b1;
                state_next = ST_UNLOAD;
            end
            ST_UNLOAD: begin
                if (out_ready) begin
                    cnt_step = 1'b1;
                    if (resp_last) begin
                        state_next = ST_IDLE;
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // Command latch, result capture, EXEC cycle counter
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            op_reg       <= OP_NOP;
            size_reg     <= 3'd0;
            scalar_reg   <= '0;
            err_reg      <= 1'b0;
            ovf_reg      <= 1'b0;
            number_reg   <= '0;
            c_reg        <= '0;
            exec_cnt_reg <= '0;
        end else begin
            if (accept_cmd) begin
                op_reg     <= cmd_opcode;
                size_reg   <= cmd_size;
                scalar_reg <= cmd_scalar;
                err_reg    <= cmd_bad;
                ovf_reg    <= 1'b0;
            end
            if (capture) begin
                c_reg      <= C_flat;
                number_reg <= number;
                ovf_reg    <= overflow_flag;
            end
            if (exec_timeout) begin
                err_reg <= 1'b1;
                ovf_reg <= 1'b0;
            end
            if (state_reg != ST_EXEC) begin
                exec_cnt_reg <= '0;
            end else if (exec_cnt_reg != '1) begin
                exec_cnt_reg <= exec_cnt_reg + CNT_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Operand slots: one register pair per (r,c) position. Every command
    // zeroes all slots so positions outside the active n x n stay 0.
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
        localparam int OFS = idx(3'(gi / MAX_DIM), 3'(gi % MAX_DIM));
        logic [ELEM_W-1:0] a_slot_reg;
        logic [ELEM_W-1:0] b_slot_reg;
        logic              hit;

        assign hit = (slot_idx == 5'(gi));

        always_ff @(posedge clock) begin
            if (reset || accept_cmd) begin
                a_slot_reg <= '0;
                b_slot_reg <= '0;
            end else if (load_beat && hit) begin
                if (state_reg == ST_LOAD_A) begin
                    a_slot_reg <= in_data;
                end else begin
                    b_slot_reg <= in_data;
                end
            end
        end

        assign A_flat[OFS +: ELEM_W] = a_slot_reg;
        assign B_flat[OFS +: ELEM_W] = b_slot_reg;
        assign c_slot[gi]            = c_reg[OFS +: ELEM_W];
    end

    // ------------------------------------------------------------------
    // Response byte. Selected purely from registered state, so it cannot
    // change while the consumer stalls.
    // ------------------------------------------------------------------
    always_comb begin
        resp_byte = '0;
        if (err_reg) begin
            resp_byte = '0;
        end else if (op_reg == OP_DET) begin
            resp_byte = number_reg;
        end else if (slot_idx < 5'(NUM_SLOTS)) begin
            resp_byte = c_slot[slot_idx];
        end
    end

    assign cmd_ready   = (state_reg == ST_IDLE);
    assign in_ready    = (state_reg == ST_LOAD_A) || (state_reg == ST_LOAD_B);
    assign busy        = (state_reg != ST_IDLE);
    assign out_valid   = (state_reg == ST_UNLOAD);
    assign out_data    = out_valid ? resp_byte : '0;
    assign out_last    = out_valid && resp_last;
    assign out_ovf     = out_valid && ovf_reg;
    assign out_err     = out_valid && err_reg;
    assign opcode      = (state_reg == ST_EXEC) ? op_reg : OP_NOP;
    assign scalar      = scalar_reg;
    assign matrix_size = size_reg;

endmodule
